// File: rtl/qspi.sv
// ---------------------------------------------------------------------------
// qspi -- quad-SPI slave, oversampled in the clk domain.
//
// The master's serial clock, chip select and data lines are brought into clk
// through 2-FF synchronizers. qspi_clk edges are detected on the synchronized
// copy, and the data lines are delayed by the same depth so that each nibble
// lines up with its clock edge.
//
// Transaction flow:
//   ncs falls -> CMD. The first byte is the command.
//     0x02   -> ADDR (3 bytes) -> DUMMY (2 qspi_clk cycles) -> TX (until ncs high)
//     other  -> RX (every following byte is reported, until ncs high)
//
// Ports:
//   clk         system clock, rising edge
//   async_reset synchronous, active-low reset (name kept from older code)
//   qspi_clk    serial clock from the master (at most clk/4)
//   qspi_ncs    chip select, active-low
//   qspi_io     4-bit data lines; driven only in TX, high-Z otherwise
//   rd_data     last byte received from the master
//   rd_valid    one-clk pulse, rd_data valid in that cycle
//   wr_data     next byte to send to the master
//   wr_valid    one-clk pulse requesting the next wr_data byte
//   start       one-clk pulse at each transaction start
// ---------------------------------------------------------------------------
module qspi (
    input  logic       clk,
    input  logic       async_reset,
    input  logic       qspi_clk,
    input  logic       qspi_ncs,
    inout  wire  [3:0] qspi_io,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic [7:0] wr_data,
    output logic       wr_valid,
    output logic       start
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        DUMMY = 3'd3,
        TX    = 3'd4,
        RX    = 3'd5
    } state_t;

    state_t     state_reg;

    // Synchronizers and edge-detect history
    logic [1:0] sclk_sync_reg;
    logic [1:0] ncs_sync_reg;
    logic [3:0] io_sync1_reg;
    logic [3:0] io_sync2_reg;
    logic       sclk_prev_reg;
    logic       ncs_prev_reg;

    // Receive / transmit datapath
    logic [3:0] rx_hi_reg;     // first (high) nibble of the byte in progress
    logic       nib_phase_reg; // 0: expecting high nibble, 1: expecting low nibble
    logic [1:0] byte_cnt_reg;  // address bytes received
    logic       dummy_cnt_reg; // dummy cycles seen
    logic [3:0] tx_nib_reg;    // nibble currently on the bus
    logic [3:0] tx_lo_reg;     // low nibble waiting to be driven
    logic       tx_phase_reg;  // 1: next TX edge drives tx_lo_reg
    logic       io_oe_reg;

    logic       sclk_rise;
    logic       ncs_fall;
    logic       ncs_high;
    logic [7:0] rx_byte;

    assign sclk_rise = sclk_sync_reg[1] & ~sclk_prev_reg;
    assign ncs_fall  = ~ncs_sync_reg[1] & ncs_prev_reg;
    assign ncs_high  = ncs_sync_reg[1];
    assign rx_byte   = {rx_hi_reg, io_sync2_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_io_drv
            assign qspi_io[gi] = io_oe_reg ? tx_nib_reg[gi] : 1'bz;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!async_reset) begin
            state_reg     <= IDLE;
            sclk_sync_reg <= 2'b00;
            ncs_sync_reg  <= 2'b00;
            io_sync1_reg  <= 4'h0;
            io_sync2_reg  <= 4'h0;
            // History cleared to 0 so a master already holding ncs low
            // does not produce a spurious start after reset.
            sclk_prev_reg <= 1'b0;
            ncs_prev_reg  <= 1'b0;
            rx_hi_reg     <= 4'h0;
            nib_phase_reg <= 1'b0;
            byte_cnt_reg  <= 2'd0;
            dummy_cnt_reg <= 1'b0;
            tx_nib_reg    <= 4'h0;
            tx_lo_reg     <= 4'h0;
            tx_phase_reg  <= 1'b0;
            io_oe_reg     <= 1'b0;
            rd_data       <= 8'h00;
            rd_valid      <= 1'b0;
            wr_valid      <= 1'b0;
            start         <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[0], qspi_clk};
            ncs_sync_reg  <= {ncs_sync_reg[0], qspi_ncs};
            io_sync1_reg  <= qspi_io;
            io_sync2_reg  <= io_sync1_reg;
            sclk_prev_reg <= sclk_sync_reg[1];
            ncs_prev_reg  <= ncs_sync_reg[1];

            rd_valid <= 1'b0;
            wr_valid <= 1'b0;
            start    <= 1'b0;

            if (ncs_high) begin
                // Deselected: drop everything, any partial byte is lost.
                state_reg     <= IDLE;
                io_oe_reg     <= 1'b0;
                nib_phase_reg <= 1'b0;
            end else if (ncs_fall) begin
                start         <= 1'b1;
                state_reg     <= CMD;
                nib_phase_reg <= 1'b0;
                byte_cnt_reg  <= 2'd0;
                dummy_cnt_reg <= 1'b0;
                tx_phase_reg  <= 1'b0;
                io_oe_reg     <= 1'b0;
            end else if (sclk_rise) begin
                case (state_reg)
                    CMD, ADDR, RX: begin
                        if (!nib_phase_reg) begin
                            rx_hi_reg     <= io_sync2_reg;
                            nib_phase_reg <= 1'b1;
                        end else begin
                            nib_phase_reg <= 1'b0;
                            rd_data       <= rx_byte;
                            rd_valid      <= 1'b1;
                            if (state_reg == CMD) begin
                                state_reg    <= (rx_byte == 8'h02) ? ADDR : RX;
                                byte_cnt_reg <= 2'd0;
                            end else if (state_reg == ADDR) begin
                                byte_cnt_reg <= byte_cnt_reg + 2'd1;
                                if (byte_cnt_reg == 2'd2) begin
                                    // Request the first TX byte ahead of the dummy cycles.
                                    wr_valid      <= 1'b1;
                                    dummy_cnt_reg <= 1'b0;
                                    state_reg     <= DUMMY;
                                end
                            end
                        end
                    end
                    DUMMY: begin
                        if (dummy_cnt_reg) begin
                            tx_nib_reg   <= wr_data[7:4];
                            tx_lo_reg    <= wr_data[3:0];
                            tx_phase_reg <= 1'b1;
                            io_oe_reg    <= 1'b1;
                            wr_valid     <= 1'b1;
                            state_reg    <= TX;
                        end else begin
                            dummy_cnt_reg <= 1'b1;
                        end
                    end
                    TX: begin
                        if (tx_phase_reg) begin
                            tx_nib_reg   <= tx_lo_reg;
                            tx_phase_reg <= 1'b0;
                        end else begin
                            // Byte boundary: load the next byte and ask for another.
                            tx_nib_reg   <= wr_data[7:4];
                            tx_lo_reg    <= wr_data[3:0];
                            tx_phase_reg <= 1'b1;
                            wr_valid     <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi.sv
// ---------------------------------------------------------------------------
// tb_qspi -- directed bench for qspi. The bench plays the bus master with
// qspi_clk at 80 ns period against a 10 ns clk, and a monitor collects the
// DUT's pulses and bytes on the falling clk edge.
// ---------------------------------------------------------------------------
module tb_qspi;

    logic       clk = 1'b0;
    logic       async_reset;
    logic       qspi_clk;
    logic       qspi_ncs;
    wire  [3:0] qspi_io;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       start;

    logic [3:0] m_io;
    logic       m_oe;
    assign qspi_io = m_oe ? m_io : 4'bz;

    always #5 clk = ~clk;

    qspi dut (
        .clk         (clk),
        .async_reset (async_reset),
        .qspi_clk    (qspi_clk),
        .qspi_ncs    (qspi_ncs),
        .qspi_io     (qspi_io),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .start       (start)
    );

    int n_vec = 0;
    int n_err = 0;

    // Monitor state
    int         n_start;
    int         n_wr;
    int         n_oe;
    logic [7:0] rd_q[$];
    logic [7:0] rx_got[$];
    logic [7:0] tx_src [0:15];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Monitor: counts pulses, logs received bytes and answers wr_valid
    // requests with the next source byte.
    initial begin
        n_start = 0; n_wr = 0; n_oe = 0;
        forever begin
            @(negedge clk);
            if (start) n_start++;
            if (rd_valid) rd_q.push_back(rd_data);
            if (dut.io_oe_reg) n_oe++;
            if (wr_valid) begin
                wr_data = tx_src[n_wr % 16];
                n_wr++;
            end
        end
    end

    task automatic clear_mon();
        n_start = 0; n_wr = 0; n_oe = 0;
        rd_q.delete();
        rx_got.delete();
    endtask

    task automatic ncs_fall();
        qspi_ncs = 1'b0;
        #80;
    endtask

    task automatic ncs_rise();
        m_oe = 1'b0;
        #40 qspi_ncs = 1'b1;
        #160;
    endtask

    task automatic send_nib(input logic [3:0] n);
        m_io = n; m_oe = 1'b1;
        #40 qspi_clk = 1'b1;
        #40 qspi_clk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(b[7:4]);
        send_nib(b[3:0]);
    endtask

    task automatic dummy_cycle();
        m_oe = 1'b0;
        #40 qspi_clk = 1'b1;
        #40 qspi_clk = 1'b0;
    endtask

    // Master samples on its rising edge.
    task automatic read_byte(output logic [7:0] b);
        #40 b[7:4] = qspi_io; qspi_clk = 1'b1;
        #40 qspi_clk = 1'b0;
        #40 b[3:0] = qspi_io; qspi_clk = 1'b1;
        #40 qspi_clk = 1'b0;
    endtask

    task automatic do_read(input int nbytes);
        logic [7:0] b;
        ncs_fall();
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        dummy_cycle();
        dummy_cycle();
        for (int i = 0; i < nbytes; i++) begin
            read_byte(b);
            rx_got.push_back(b);
        end
        ncs_rise();
    endtask

    function automatic logic [7:0] wpat(input int i);
        logic [7:0] v;
        v = 8'h3C + 8'(i * 17);
        return v;
    endfunction

    task automatic do_write(input logic [7:0] cmd, input int nbytes);
        ncs_fall();
        send_byte(cmd);
        for (int i = 0; i < nbytes; i++) send_byte(wpat(i));
        ncs_rise();
    endtask

    task automatic check_write(input string tag, input logic [7:0] cmd, input int nbytes);
        check({tag, "_rd_cnt"}, rd_q.size(), nbytes + 1);
        if (rd_q.size() == nbytes + 1) begin
            check({tag, "_cmd"}, rd_q[0], cmd);
            for (int i = 0; i < nbytes; i++)
                check($sformatf("%s_byte%0d", tag, i), rd_q[i+1], wpat(i));
        end
        check({tag, "_wr_valid_cnt"}, n_wr, 0);
        check({tag, "_io_driven"}, n_oe, 0);
    endtask

    task automatic check_read(input string tag, input int nbytes);
        check({tag, "_rd_cnt"}, rd_q.size(), 4);
        if (rd_q.size() == 4) begin
            check({tag, "_cmd"}, rd_q[0], 8'h02);
            check({tag, "_a0"}, rd_q[1], 8'h12);
            check({tag, "_a1"}, rd_q[2], 8'h34);
            check({tag, "_a2"}, rd_q[3], 8'h56);
        end
        check({tag, "_wr_req_ge_n"}, 32'(n_wr >= nbytes), 1);
        for (int i = 0; i < nbytes; i++)
            check($sformatf("%s_tx%0d", tag, i), rx_got[i], tx_src[i]);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tx_src[i] = 8'hA5 ^ 8'(i * 29);
        async_reset = 1'b0;
        qspi_clk    = 1'b0;
        qspi_ncs    = 1'b1;
        m_io        = 4'h0;
        m_oe        = 1'b0;
        wr_data     = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_start", start, 0);
        check("rst_io_oe", dut.io_oe_reg, 0);
        async_reset = 1'b1;
        #203;

        // Read transaction: command 0x02, 3 address bytes, 10 data bytes.
        clear_mon();
        do_read(10);
        check("rd_start", n_start, 1);
        check_read("rd", 10);
        check("rd_io_released", dut.io_oe_reg, 0);

        // Write transaction: command 0x03, 20 bytes.
        clear_mon();
        do_write(8'h03, 20);
        check("wr_start", n_start, 1);
        check_write("wr", 8'h03, 20);

        // Back-to-back: read, ncs high two qspi periods, write.
        clear_mon();
        do_read(3);
        check_read("b2b_rd", 3);
        clear_mon();
        do_write(8'h81, 5);
        check("b2b_wr_start", n_start, 1);
        check_write("b2b_wr", 8'h81, 5);

        // Abort after one nibble of the command.
        clear_mon();
        ncs_fall();
        send_nib(4'h0);
        ncs_rise();
        check("abort_rd_cnt", rd_q.size(), 0);
        clear_mon();
        do_write(8'h05, 2);
        check_write("after_abort", 8'h05, 2);

        // Partial trailing byte is dropped.
        clear_mon();
        ncs_fall();
        send_byte(8'h07);
        send_byte(wpat(0));
        send_nib(4'hF);
        ncs_rise();
        check_write("partial", 8'h07, 1);

        // Reset asserted during TX.
        clear_mon();
        ncs_fall();
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        dummy_cycle();
        dummy_cycle();
        begin
            logic [7:0] b;
            read_byte(b);
            check("rst_tx_byte0", b, tx_src[0]);
        end
        #40;
        check("rst_tx_driving", dut.io_oe_reg, 1);
        @(negedge clk);
        async_reset = 1'b0;
        @(negedge clk);
        check("rst_tx_io_oe", dut.io_oe_reg, 0);
        check("rst_tx_rd_data", rd_data, 8'h00);
        check("rst_tx_rd_valid", rd_valid, 0);
        check("rst_tx_wr_valid", wr_valid, 0);
        check("rst_tx_start", start, 0);
        async_reset = 1'b1;
        ncs_rise();
        clear_mon();
        do_write(8'h09, 3);
        check("post_rst_start", n_start, 1);
        check_write("post_rst", 8'h09, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
